// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer: default depth, word-address width
// and the entry record handed to the forwarding matcher.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int WADDR_W  = 30;

    typedef struct packed {
        logic               valid;
        logic [WADDR_W-1:0] waddr;
        logic [31:0]        data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding lookup: compares a load word address against every entry
// and returns the data of the youngest valid match (youngest = just before tail).
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic [PTR_W-1:0]      tail_i,
    input  logic [WADDR_W-1:0]    ld_waddr_i,
    output logic                  hit_o,
    output logic [31:0]           data_o
);

    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = entries_i[gi].valid && (entries_i[gi].waddr == ld_waddr_i);
        end
    endgenerate

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later hits override.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail_i - PTR_W'(i);
            if (match[idx]) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the core and data memory, with tail
// coalescing, full-buffer stall and youngest-match load forwarding.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    output logic                       stall,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hit,
    output logic [31:0]                ld_data,
    output logic                       mem_valid,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [WADDR_W-1:0] waddr_q [DEPTH];
    logic [31:0]        data_q  [DEPTH];

    logic [PTR_W-1:0]   last_idx;
    logic               full;
    logic               coalesce;
    logic               enq;
    logic               pop;
    sb_entry_t [DEPTH-1:0] entries;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign last_idx = tail_q - PTR_W'(1);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

    // The head may already be on the memory bus, so it is never rewritten.
    assign coalesce = st_valid && valid_q[last_idx] && (last_idx != head_q)
                      && (waddr_q[last_idx] == st_addr[31:2]);
    assign enq      = st_valid && !coalesce && !full;
    assign pop      = !empty && mem_ready;
    assign stall    = st_valid && full && !coalesce;

    assign mem_valid = !empty;
    assign mem_addr  = {waddr_q[head_q], 2'b00};
    assign mem_wdata = data_q[head_q];
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            waddr_q[tail_q] <= st_addr[31:2];
            data_q[tail_q]  <= st_data;
        end else if (coalesce) begin
            data_q[last_idx] <= st_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entries[gi] = '{valid: valid_q[gi], waddr: waddr_q[gi], data: data_q[gi]};
        end
    endgenerate

    sb_fwd_match #(
        .DEPTH(DEPTH)
    ) u_fwd (
        .entries_i  (entries),
        .tail_i     (tail_q),
        .ld_waddr_i (ld_addr[31:2]),
        .hit_o      (ld_hit),
        .data_o     (ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        stall;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [2:0]  count;
    logic        empty;

    int errors = 0;
    int checks = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .stall     (stall),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: an ordered list of pending word writes, oldest first.
    typedef struct {
        logic [29:0] waddr;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t mq[$];

    always @(negedge clk) begin
        int          n;
        logic        m_coal;
        logic        m_full;
        logic        m_hit;
        logic [31:0] m_ld;
        m_ent_t      e;
        if (reset) begin
            mq.delete();
        end else begin
            n      = mq.size();
            m_full = (n == DEPTH);
            m_coal = st_valid && (n >= 2) && (mq[n-1].waddr == st_addr[31:2]);
            m_hit  = 1'b0;
            m_ld   = 32'h0;
            for (int i = 0; i < n; i++) begin
                if (mq[i].waddr == ld_addr[31:2]) begin
                    m_hit = 1'b1;
                    m_ld  = mq[i].data;
                end
            end
            chk("m_count", {29'h0, count}, n);
            chk("m_empty", empty, n == 0);
            chk("m_mem_valid", mem_valid, n != 0);
            chk("m_stall", stall, st_valid && m_full && !m_coal);
            chk("m_ld_hit", ld_hit, m_hit);
            chk("m_ld_data", ld_data, m_ld);
            if (n > 0) begin
                chk("m_mem_addr", mem_addr, {mq[0].waddr, 2'b00});
                chk("m_mem_wdata", mem_wdata, mq[0].data);
            end
            if (m_coal) begin
                mq[n-1].data = st_data;
            end else if (st_valid && !m_full) begin
                e.waddr = st_addr[31:2];
                e.data  = st_data;
                mq.push_back(e);
            end
            if (n > 0 && mem_ready) begin
                void'(mq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k         = 0;
        st_valid  = 1'b0;
        mem_ready = 1'b1;
        #1;
        while (!empty && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (!empty) begin
            errors++;
            $display("FAIL drain_timeout: got count=%0d required 0", count);
        end
        mem_ready = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
    endtask

    initial begin
        logic held;
        int   k;
        reset     = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        ld_addr   = '0;
        mem_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ld_hit", ld_hit, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_count", {29'h0, count}, 0);
        chk("rst_stall", stall, 0);

        $display("scenario: single store 0x40");
        mem_ready = 1'b1;
        put(32'h40, 32'hDEADBEEF);
        st_valid = 1'b0;
        #1;
        chk("s1_mem_valid", mem_valid, 1);
        chk("s1_mem_addr", mem_addr, 32'h40);
        chk("s1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        chk("s1_empty_after_pop", empty, 1);

        $display("scenario: fill and stall");
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(32'(i * 4), 32'h100 + 32'(i));
        st_addr = 32'h10;
        st_data = 32'h104;
        #1;
        chk("s2_count_full", {29'h0, count}, 4);
        chk("s2_stall", stall, 1);
        tick();
        chk("s2_stall_held", stall, 1);
        mem_ready = 1'b1;
        #1;
        chk("s2_stall_while_pop", stall, 1);
        chk("s2_head_first", mem_addr, 32'h00);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("s2_count_after_pop", {29'h0, count}, 3);
        chk("s2_stall_released", stall, 0);
        chk("s2_next_head", mem_addr, 32'h04);
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h10;
        #1;
        chk("s2_count_refill", {29'h0, count}, 4);
        chk("s2_fifth_fwd", ld_data, 32'h104);
        drain();

        $display("scenario: coalesce tail");
        put(32'h20, 32'd1);
        put(32'h24, 32'd2);
        put(32'h24, 32'd3);
        st_valid = 1'b0;
        ld_addr  = 32'h26;
        #1;
        chk("s3_count", {29'h0, count}, 2);
        chk("s3_ld_hit", ld_hit, 1);
        chk("s3_ld_data", ld_data, 32'd3);
        ld_addr = 32'h20;
        #1;
        chk("s3_ld_head", ld_data, 32'd1);
        drain();

        $display("scenario: youngest match and order");
        put(32'h80, 32'd5);
        put(32'h84, 32'd6);
        put(32'h80, 32'd7);
        st_valid = 1'b0;
        ld_addr  = 32'h80;
        #1;
        chk("s4_count", {29'h0, count}, 3);
        chk("s4_youngest", ld_data, 32'd7);
        mem_ready = 1'b1;
        #1;
        chk("s4_d0_addr", mem_addr, 32'h80);
        chk("s4_d0_data", mem_wdata, 32'd5);
        tick();
        chk("s4_d1_addr", mem_addr, 32'h84);
        chk("s4_d1_data", mem_wdata, 32'd6);
        tick();
        chk("s4_d2_addr", mem_addr, 32'h80);
        chk("s4_d2_data", mem_wdata, 32'd7);
        ld_addr = 32'h84;
        #1;
        chk("s4_popped_no_hit", ld_hit, 0);
        tick();
        chk("s4_drained", empty, 1);
        mem_ready = 1'b0;

        $display("scenario: full streaming with wrap");
        for (int i = 0; i < 4; i++) put(32'h100 + 32'(i * 4), 32'(i));
        mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h200 + 32'(i * 4);
            st_data  = 32'h1000 + 32'(i);
            k        = 0;
            do begin
                #1;
                held = stall;
                tick();
                k++;
            end while (held && k < 10);
        end
        drain();

        $display("scenario: random traffic");
        held = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!held) begin
                st_valid = ($urandom_range(0, 9) < 6);
                st_addr  = 32'h1000 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
                st_data  = $urandom;
            end
            mem_ready = ($urandom_range(0, 1) == 1);
            ld_addr   = 32'h1000 + (32'($urandom_range(0, 6)) << 2) + 32'($urandom_range(0, 3));
            #1;
            held = st_valid && stall;
            tick();
        end
        drain();

        $display("scenario: reset during memory offer");
        put(32'h300, 32'hA);
        put(32'h304, 32'hB);
        st_valid = 1'b0;
        #1;
        chk("s6_offer", mem_valid, 1);
        reset = 1'b1;
        #1;
        chk("s6_async_drop", mem_valid, 0);
        chk("s6_async_empty", empty, 1);
        tick();
        tick();
        reset   = 1'b0;
        ld_addr = 32'h300;
        #1;
        chk("s6_no_hit_300", ld_hit, 0);
        ld_addr = 32'h304;
        #1;
        chk("s6_no_hit_304", ld_hit, 0);
        chk("s6_ld_data_zero", ld_data, 0);
        put(32'h308, 32'hC);
        st_valid = 1'b0;
        #1;
        chk("s6_after_reset_store", {29'h0, count}, 1);
        chk("s6_after_reset_addr", mem_addr, 32'h308);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
